// File: rtl/pwm_peripheral.sv
// Shared-duty PWM driver: 16 lines, each forced low, forced high or PWM-driven.
// Latency: out registered one cycle after the counter/shadow state and inputs.
// Backpressure: none; register values are consumed as levels every cycle.
module pwm_peripheral #(
    parameter int DIV = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] en_out,
    input  logic [15:0] en_pwm,
    input  logic [7:0]  duty,
    output logic [15:0] out,
    output logic        period_start
);

    generate
        if (DIV < 1 || DIV > 65535) begin : g_div_check
            $error("pwm_peripheral: DIV must be in 1..65535");
        end
    endgenerate

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [7:0]  C_LAST   = 8'd254;

    logic [15:0] p;
    logic [7:0]  c;
    logic [7:0]  s;
    logic        first;
    logic        tick;
    logic        wrap;
    logic        load;
    logic        pwm;

    assign tick = (p == DIV_LAST);
    assign wrap = tick && (c == C_LAST);
    // Shadow loads only at a period boundary (or once after reset), so no runt pulses.
    assign load = ~rst & (first | wrap);
    assign pwm  = (c < s);

    assign period_start = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            p     <= 16'd0;
            c     <= 8'd0;
            s     <= 8'd0;
            first <= 1'b1;
            out   <= 16'h0000;
        end else begin
            p <= tick ? 16'd0 : p + 16'd1;
            if (tick) begin
                c <= (c == C_LAST) ? 8'd0 : c + 8'd1;
            end
            if (load) begin
                s     <= duty;
                first <= 1'b0;
            end
            out <= en_out & (~en_pwm | {16{pwm}});
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized bench for pwm_peripheral (DIV=4 and DIV=1 instances) against a time-based reference model.
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out4;
    logic [15:0] out1;
    logic        ps4;
    logic        ps1;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.DIV(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty         (duty),
        .out          (out4),
        .period_start (ps4)
    );

    pwm_peripheral #(.DIV(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty         (duty),
        .out          (out1),
        .period_start (ps1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    // Reference model: position in the period follows from elapsed cycles since release.
    int          m_div     [2] = '{4, 1};
    bit          m_valid;
    bit          m_started [2];
    int          m_k       [2];
    logic [7:0]  m_s       [2];
    logic        m_ps      [2];
    logic [15:0] m_out     [2];
    bit          m_first_ld[2];
    // Period_start spacing tracker.
    bit          g_have    [2];
    bit          g_post    [2];
    int          g_last    [2];

    task automatic model_step(input int d);
        int  per;
        int  stp;
        bit  ld;
        per = 255 * m_div[d];
        m_first_ld[d] = 1'b0;
        if (rst) begin
            m_ps[d]      = 1'b0;
            m_out[d]     = 16'h0000;
            m_started[d] = 1'b0;
            m_s[d]       = 8'd0;
        end else begin
            if (!m_started[d]) begin
                ld  = 1'b1;
                stp = 0;
                m_first_ld[d] = 1'b1;
            end else begin
                ld  = ((m_k[d] % per) == per - 1);
                stp = (m_k[d] / m_div[d]) % 255;
            end
            m_ps[d]  = ld;
            m_out[d] = en_out & (~en_pwm | ((stp < int'(m_s[d])) ? 16'hFFFF : 16'h0000));
            if (ld) m_s[d] = duty;
            if (!m_started[d]) begin
                m_started[d] = 1'b1;
                m_k[d]       = 1;
            end else begin
                m_k[d]++;
            end
        end
    endtask

    task automatic gap_track(input int d, input logic ps_obs);
        if (rst) begin
            g_have[d] = 1'b0;
        end else if (ps_obs) begin
            if (g_have[d] && !g_post[d])
                check(d == 0 ? "gap4" : "gap1", cycle - g_last[d], 255 * m_div[d]);
            g_have[d] = 1'b1;
            g_post[d] = m_first_ld[d];
            g_last[d] = cycle;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (rst) m_valid = 1'b1;
        for (int d = 0; d < 2; d++) model_step(d);
        if (m_valid) begin
            check("ps4", ps4, m_ps[0]);
            check("ps1", ps1, m_ps[1]);
            gap_track(0, ps4);
            gap_track(1, ps1);
        end
        @(posedge clk);
        #1;
        cycle++;
        if (m_valid) begin
            check("out4", out4, m_out[0]);
            check("out1", out1, m_out[1]);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        m_valid = 1'b0;
        rst     = 1'b1;
        en_out  = 16'h0000;
        en_pwm  = 16'h0000;
        duty    = 8'($urandom);
        run(3);
        check("rst_out4", out4, 16'h0000);
        check("rst_ps4", ps4, 1'b0);

        // Outputs disabled: always low, period_start spacing still checked.
        rst = 1'b0;
        run(2100);

        // Static high, then a narrower enable set.
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        run(1);
        check("static_hi", out4, 16'hFFFF);
        en_out = 16'h00F0;
        run(1);
        check("static_f0", out4, 16'h00F0);
        run(5);

        // 50% duty on line 0.
        duty   = 8'd128;
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        run(2100);

        // Extremes across boundaries.
        duty = 8'd0;
        run(1100);
        duty = 8'd255;
        run(1100);

        // Mid-period duty change.
        duty = 8'd64;
        run(1100);
        run(500);
        duty = 8'd192;
        run(1100);

        // One-cycle reset in the high phase.
        run(100);
        rst = 1'b1;
        run(1);
        check("midrst_out4", out4, 16'h0000);
        rst = 1'b0;
        run(600);

        // Random traffic with occasional resets.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: duty = 8'($urandom);
                1: en_out = 16'($urandom);
                2: en_pwm = 16'($urandom);
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b1;
                        run(1);
                        rst = 1'b0;
                    end else begin
                        duty = 8'($urandom_range(0, 1) ? 0 : 255);
                    end
                end
            endcase
            run($urandom_range(1, 300));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
